sample_rate_ctrl: RTL



---
 rtl/ecg_rate_pkg.sv | 21 ++
 rtl/switch_debounce.sv | 57 +++++
 rtl/sample_rate_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/ecg_rate_pkg.sv
// Shared constants and rate encoding for the ECG sample-rate path.
package ecg_rate_pkg;

    localparam int unsigned RATE_W = 3;
    localparam int unsigned CNT_W  = 12;

    localparam int unsigned L1_DEF = 3592;
    localparam int unsigned L2_DEF = 1792;
    localparam int unsigned L3_DEF = 894;
    localparam int unsigned L4_DEF = 444;
    localparam int unsigned L5_DEF = 220;

    typedef enum logic [RATE_W-1:0] {
        R0 = 3'd0,
        R1 = 3'd1,
        R2 = 3'd2,
        R3 = 3'd3,
        R4 = 3'd4
    } rate_t;

endpackage

// File: rtl/switch_debounce.sv
// Synchronizes and debounces the rate switch; pulses step_o on every debounced edge.
module switch_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic switch_i,
    output logic sw_db_o,
    output logic step_o
);

    localparam int unsigned RunW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    if (DEB_CYCLES < 2) begin : g_bad_deb
        $error("switch_debounce: DEB_CYCLES must be at least 2");
    end

    logic            sync1_q, sync2_q;
    logic            db_q, db_d;
    logic            step_q, step_d;
    logic [RunW-1:0] run_q, run_d;

    // run_q counts prior consecutive cycles that differed; the DEB_CYCLES-th one flips the level.
    always_comb begin
        db_d   = db_q;
        run_d  = '0;
        step_d = 1'b0;
        if (sync2_q != db_q) begin
            if (run_q == RunW'(DEB_CYCLES - 1)) begin
                db_d   = sync2_q;
                step_d = 1'b1;
            end else begin
                run_d = run_q + RunW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            run_q   <= '0;
            step_q  <= 1'b0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            run_q   <= run_d;
            step_q  <= step_d;
        end
    end

    assign sw_db_o = db_q;
    assign step_o  = step_q;

endmodule

// File: rtl/sample_rate_ctrl.sv
// ECG sample-rate controller: switch-driven rate request, period-aligned rate apply, strobe timer.
module sample_rate_ctrl
    import ecg_rate_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned L1         = L1_DEF,
    parameter int unsigned L2         = L2_DEF,
    parameter int unsigned L3         = L3_DEF,
    parameter int unsigned L4         = L4_DEF,
    parameter int unsigned L5         = L5_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              switch,
    input  logic              en,
    output logic              sample_tick,
    output logic [CNT_W-1:0]  load,
    output logic [RATE_W-1:0] rate_idx,
    output logic              ds,
    output logic              dc
);

    localparam int unsigned LMax = (1 << CNT_W) - 1;

    if (L1 < 1 || L1 > LMax || L2 < 1 || L2 > LMax || L3 < 1 || L3 > LMax ||
        L4 < 1 || L4 > LMax || L5 < 1 || L5 > LMax) begin : g_bad_reload
        $error("sample_rate_ctrl: reload values must lie in 1..4095");
    end

    logic             step;
    logic             sw_db;
    rate_t            req_q, req_d;
    rate_t            app_q, app_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    switch_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_switch_debounce (
        .clk     (clk),
        .rst     (rst),
        .switch_i(switch),
        .sw_db_o (sw_db),
        .step_o  (step)
    );

    function automatic logic [CNT_W-1:0] reload_of(input rate_t idx);
        unique case (idx)
            R0:      reload_of = CNT_W'(L1);
            R1:      reload_of = CNT_W'(L2);
            R2:      reload_of = CNT_W'(L3);
            R3:      reload_of = CNT_W'(L4);
            R4:      reload_of = CNT_W'(L5);
            default: reload_of = CNT_W'(L1);
        endcase
    endfunction

    // R4 is terminal: further steps are absorbed until reset.
    always_comb begin
        req_d = req_q;
        if (step) begin
            unique case (req_q)
                R0:      req_d = R1;
                R1:      req_d = R2;
                R2:      req_d = R3;
                R3:      req_d = R4;
                R4:      req_d = R4;
                default: req_d = R0;
            endcase
        end
    end

    // Requested rate is only adopted at the period boundary so no period is cut short.
    always_comb begin
        app_d = app_q;
        cnt_d = cnt_q;
        if (en) begin
            if (cnt_q == '0) begin
                app_d = req_q;
                cnt_d = reload_of(req_q) - CNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= R0;
            app_q <= R0;
            cnt_q <= CNT_W'(L1 - 1);
        end else begin
            req_q <= req_d;
            app_q <= app_d;
            cnt_q <= cnt_d;
        end
    end

    assign sample_tick = en && !rst && (cnt_q == '0);
    assign load        = reload_of(app_q);
    assign rate_idx    = req_q;
    assign ds          = (app_q >= R3);
    assign dc          = (app_q == R4);

endmodule
